dff_reg_arbiter: RTL and testbench

//  Round-robin arbiter and write sequencer for one shared WIDTH-bit register built from d_flip_flop cells.

---
 rtl/dff_reg_arbiter.sv | 127 ++++++++++++
 tb/tb_dff_reg_arbiter.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/dff_reg_arbiter.sv
// Round-robin arbiter and write sequencer for a shared WIDTH-bit register.
// One requester is granted at a time; its data slice is loaded one cycle after
// the grant if it still requests, followed by a one-cycle done pulse.
module dff_reg_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned IDX_W = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  output logic                  done,
  output logic [IDX_W-1:0]      owner,
  output logic                  busy,
  output logic [WIDTH-1:0]      q,
  output logic [WIDTH-1:0]      ql
);

  typedef enum logic [1:0] {StIdle, StGrant, StDone} state_e;

  state_e            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  gidx_q, gidx_d;
  logic [WIDTH-1:0]  q_q, q_d;
  logic [WIDTH-1:0]  ql_q, ql_d;

  logic              found;
  logic [IDX_W-1:0]  pick;
  logic [IDX_W-1:0]  cand;

  // Search ptr+1, ptr+2, ... modulo NREQ for the first active request.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IDX_W'((32'(ptr_q) + k) % NREQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = done_q;
    busy_d  = busy_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    q_d     = q_q;
    ql_d    = ql_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          gnt_d   = NREQ'(1) << pick;
          gidx_d  = pick;
          busy_d  = 1'b1;
          state_d = StGrant;
        end
      end
      StGrant: begin
        gnt_d = '0;
        if (req[gidx_q]) begin
          q_d     = wdata[gidx_q*WIDTH +: WIDTH];
          ql_d    = ~wdata[gidx_q*WIDTH +: WIDTH];
          owner_d = gidx_q;
          ptr_d   = gidx_q;
          done_d  = 1'b1;
          state_d = StDone;
        end else begin
          // Requester withdrew: abort without touching q, owner or ptr.
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      StDone: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset wins over any in-flight load.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      owner_q <= '0;
      ptr_q   <= IDX_W'(NREQ - 1);
      gidx_q  <= '0;
      q_q     <= '0;
      ql_q    <= '1;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      q_q     <= q_d;
      ql_q    <= ql_d;
    end
  end

  assign gnt   = gnt_q;
  assign done  = done_q;
  assign busy  = busy_q;
  assign owner = owner_q;
  assign q     = q_q;
  assign ql    = ql_q;

endmodule

// File: tb/tb_dff_reg_arbiter.sv
// Bench for dff_reg_arbiter: per-cycle vector table plus a load scoreboard.
module tb_dff_reg_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] wdata;
  logic [3:0]  gnt;
  logic        done;
  logic [1:0]  owner;
  logic        busy;
  logic [7:0]  q;
  logic [7:0]  ql;

  int n_checks = 0;
  int n_pass   = 0;

  dff_reg_arbiter #(.NREQ(4), .WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .wdata (wdata),
    .gnt   (gnt),
    .done  (done),
    .owner (owner),
    .busy  (busy),
    .q     (q),
    .ql    (ql)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic        done;
    logic        busy;
    logic [7:0]  q;
    logic [1:0]  owner;
  } vec_t;

  typedef struct {
    logic [1:0] owner;
    logic [7:0] q;
  } load_t;

  vec_t  vecs[$];
  load_t sb[$];
  logic  running = 1'b1;

  localparam logic [31:0] WD = 32'h1312_1110;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic add(input logic r, input logic [3:0] rq, input logic [31:0] wd,
                     input logic [3:0] g, input logic d, input logic b,
                     input logic [7:0] qq, input logic [1:0] o);
    vec_t v;
    v.rst = r; v.req = rq; v.wdata = wd; v.gnt = g;
    v.done = d; v.busy = b; v.q = qq; v.owner = o;
    vecs.push_back(v);
  endtask

  // Load monitor: every done pulse must match the oldest expected load.
  always @(negedge clk) begin
    if (running) begin
      check("ql_inv", {24'h0, ql}, {24'h0, ~q});
      check("gnt_onehot", {31'h0, $onehot0(gnt)}, 32'h1);
      check("gnt_done_excl", {31'h0, (|gnt) & done}, 32'h0);
      if (done) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_done", 32'h1, 32'h0);
        end else begin
          load_t e;
          e = sb.pop_front();
          check("sb_q", {24'h0, q}, {24'h0, e.q});
          check("sb_owner", {30'h0, owner}, {30'h0, e.owner});
        end
      end
    end
  end

  initial begin
    // T1 reset with all requests active
    add(1, 4'b1111, WD, 4'b0000, 0, 0, 8'h00, 0);
    add(1, 4'b1111, WD, 4'b0000, 0, 0, 8'h00, 0);
    // T3 round-robin 0,1,2,3,0
    add(0, 4'b1111, WD, 4'b0001, 0, 1, 8'h00, 0);
    add(0, 4'b1111, WD, 4'b0000, 1, 1, 8'h10, 0);
    add(0, 4'b1111, WD, 4'b0000, 0, 0, 8'h10, 0);
    add(0, 4'b1111, WD, 4'b0010, 0, 1, 8'h10, 0);
    add(0, 4'b1111, WD, 4'b0000, 1, 1, 8'h11, 1);
    add(0, 4'b1111, WD, 4'b0000, 0, 0, 8'h11, 1);
    add(0, 4'b1111, WD, 4'b0100, 0, 1, 8'h11, 1);
    add(0, 4'b1111, WD, 4'b0000, 1, 1, 8'h12, 2);
    add(0, 4'b1111, WD, 4'b0000, 0, 0, 8'h12, 2);
    add(0, 4'b1111, WD, 4'b1000, 0, 1, 8'h12, 2);
    add(0, 4'b1111, WD, 4'b0000, 1, 1, 8'h13, 3);
    add(0, 4'b1111, WD, 4'b0000, 0, 0, 8'h13, 3);
    add(0, 4'b1111, WD, 4'b0001, 0, 1, 8'h13, 3);
    add(0, 4'b1111, WD, 4'b0000, 1, 1, 8'h10, 0);
    add(0, 4'b0000, WD, 4'b0000, 0, 0, 8'h10, 0);
    // T2 single request, slice 2 = A5
    add(0, 4'b0100, 32'h13A5_1110, 4'b0100, 0, 1, 8'h10, 0);
    add(0, 4'b0100, 32'h13A5_1110, 4'b0000, 1, 1, 8'hA5, 2);
    add(0, 4'b0100, 32'h13A5_1110, 4'b0000, 0, 0, 8'hA5, 2);
    // T4 abort: req[1] dropped during GRANT, then 0011 grants 0
    add(0, 4'b0010, WD, 4'b0010, 0, 1, 8'hA5, 2);
    add(0, 4'b0000, WD, 4'b0000, 0, 0, 8'hA5, 2);
    add(0, 4'b0011, WD, 4'b0001, 0, 1, 8'hA5, 2);
    add(0, 4'b0011, WD, 4'b0000, 1, 1, 8'h10, 0);
    add(0, 4'b0000, WD, 4'b0000, 0, 0, 8'h10, 0);
    // T5 reset during GRANT with slice 2 = FF
    add(0, 4'b0100, 32'h13FF_1110, 4'b0100, 0, 1, 8'h10, 0);
    add(1, 4'b0100, 32'h13FF_1110, 4'b0000, 0, 0, 8'h00, 0);
    add(0, 4'b1111, 32'h13FF_1110, 4'b0001, 0, 1, 8'h00, 0);
    add(0, 4'b1111, WD, 4'b0000, 1, 1, 8'h10, 0);
    add(0, 4'b0000, WD, 4'b0000, 0, 0, 8'h10, 0);
    // T6 wrap-around: make owner 3, then 1001 grants 0 then 3
    add(0, 4'b1000, WD, 4'b1000, 0, 1, 8'h10, 0);
    add(0, 4'b1100, WD, 4'b0000, 1, 1, 8'h13, 3);
    add(0, 4'b1001, WD, 4'b0000, 0, 0, 8'h13, 3);
    add(0, 4'b1001, WD, 4'b0001, 0, 1, 8'h13, 3);
    add(0, 4'b1001, WD, 4'b0000, 1, 1, 8'h10, 0);
    add(0, 4'b1001, WD, 4'b0000, 0, 0, 8'h10, 0);
    add(0, 4'b1001, WD, 4'b1000, 0, 1, 8'h10, 0);
    add(0, 4'b1001, WD, 4'b0000, 1, 1, 8'h13, 3);
    add(0, 4'b0000, WD, 4'b0000, 0, 0, 8'h13, 3);

    rst = 1'b1; req = '0; wdata = WD;
    @(negedge clk);
    foreach (vecs[i]) begin
      rst = vecs[i].rst; req = vecs[i].req; wdata = vecs[i].wdata;
      if (vecs[i].done) begin
        load_t e;
        e.owner = vecs[i].owner;
        e.q     = vecs[i].q;
        sb.push_back(e);
      end
      @(posedge clk);
      #1;
      check($sformatf("v%0d_gnt", i), {28'h0, gnt}, {28'h0, vecs[i].gnt});
      check($sformatf("v%0d_done", i), {31'h0, done}, {31'h0, vecs[i].done});
      check($sformatf("v%0d_busy", i), {31'h0, busy}, {31'h0, vecs[i].busy});
      check($sformatf("v%0d_q", i), {24'h0, q}, {24'h0, vecs[i].q});
      check($sformatf("v%0d_ql", i), {24'h0, ql}, {24'h0, ~vecs[i].q});
      check($sformatf("v%0d_owner", i), {30'h0, owner}, {30'h0, vecs[i].owner});
    end
    @(negedge clk);
    running = 1'b0;
    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
